icache_ctrl: RTL and testbench

//  Direct-mapped instruction cache and controller between the CPU fetch stage and inst_memory-style word storage.
//  The backing store is reached over a req/ack handshake with variable latency.

---
 rtl/icache_ctrl.sv | 144 ++++++++++++++
 tb/tb_icache_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped instruction cache with word-by-word refill controller
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu_req, cpu_addr     fetch request and byte address (held until cpu_ready)
//   cpu_ready, cpu_inst   fetch completion and instruction word (0 when not ready)
//   flush                 one-cycle pulse invalidating all lines
//   mem_req, mem_addr     refill word request and word-aligned address
//   mem_ack, mem_rdata    refill word completion and data
//   hit_cnt, miss_cnt     saturating performance counters
module icache_ctrl #(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_req,
    input  logic [31:0]      cpu_addr,
    output logic             cpu_ready,
    output logic [31:0]      cpu_inst,
    input  logic             flush,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t             state;
    logic [SETS-1:0]    valid;
    logic [TAG_W-1:0]   tag_mem  [SETS];
    logic [31:0]        data_mem [SETS*LINE_WORDS];

    logic [IDX_W-1:0]   ref_idx;
    logic [TAG_W-1:0]   ref_tag;
    logic [OFF_W-1:0]   k;
    logic               flush_pend;
    // Set for the one IDLE cycle after a successful refill, when the stalled
    // fetch is served; that completion belongs to the miss, not to hit_cnt.
    logic               fill_ret;

    logic [OFF_W-1:0]   c_off;
    logic [IDX_W-1:0]   c_idx;
    logic [TAG_W-1:0]   c_tag;
    logic               hit;
    logic               fill_we;
    logic               fill_last;
    logic [1:0]         unused_byte_bits;

    assign c_off = cpu_addr[OFF_W+1:2];
    assign c_idx = cpu_addr[IDX_W+OFF_W+1:OFF_W+2];
    assign c_tag = cpu_addr[31:IDX_W+OFF_W+2];
    assign unused_byte_bits = cpu_addr[1:0];

    // A flush in the same cycle wins over the hit.
    assign hit = (state == IDLE) && cpu_req && !flush && valid[c_idx]
                 && (tag_mem[c_idx] == c_tag);

    assign cpu_ready = hit;
    assign cpu_inst  = hit ? data_mem[{c_idx, c_off}] : 32'h0;

    assign fill_we   = (state == REFILL) && mem_req && mem_ack;
    assign fill_last = fill_we && (&k);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid      <= '0;
            ref_idx    <= '0;
            ref_tag    <= '0;
            k          <= '0;
            flush_pend <= 1'b0;
            fill_ret   <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= 32'h0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            fill_ret <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit && !fill_ret && (hit_cnt != {CNT_W{1'b1}}))
                        hit_cnt <= hit_cnt + 1'b1;
                    if (flush)
                        valid <= '0;
                    if (cpu_req && !hit) begin
                        ref_idx        <= c_idx;
                        ref_tag        <= c_tag;
                        k              <= '0;
                        valid[c_idx]   <= 1'b0;
                        mem_req        <= 1'b1;
                        mem_addr       <= {cpu_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                        state          <= REFILL;
                        if (miss_cnt != {CNT_W{1'b1}})
                            miss_cnt <= miss_cnt + 1'b1;
                    end
                end
                REFILL: begin
                    if (flush)
                        flush_pend <= 1'b1;
                    if (fill_we) begin
                        k <= k + 1'b1;
                        if (&k) begin
                            mem_req <= 1'b0;
                            state   <= IDLE;
                            // A flush seen at any point of the refill, including
                            // the final ack cycle, discards the new line.
                            if (flush_pend || flush) begin
                                valid      <= '0;
                                flush_pend <= 1'b0;
                            end else begin
                                valid[ref_idx] <= 1'b1;
                                fill_ret       <= 1'b1;
                            end
                        end else begin
                            mem_addr <= mem_addr + 32'd4;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid[] alone decides usability.
    always_ff @(posedge clk) begin
        if (fill_we)
            data_mem[{ref_idx, k}] <= mem_rdata;
        if (fill_last)
            tag_mem[ref_idx] <= ref_tag;
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - directed scoreboard bench for icache_ctrl
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = 32'h0;
    logic        cpu_ready;
    logic [31:0] cpu_inst;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int checks = 0;
    int errors = 0;
    int lat = 2;
    int wait_cnt = 0;
    int ack_count = 0;

    logic [31:0] exp_inst_q[$];
    logic [31:0] exp_addr_q[$];

    icache_ctrl #(.SETS(16), .LINE_WORDS(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .cpu_inst(cpu_inst),
        .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h8C010001;
            32'h0000_0004: return 32'h24010005;
            32'h0000_0008: return 32'h10210007;
            32'h0000_0018: return 32'h00011021;
            32'h0000_001C: return 32'hAC620001;
            32'h0000_0100: return 32'h11110100;
            default:       return {16'hD00D, a[15:0]};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Backing memory: acks each request after lat idle cycles; ack is one cycle wide.
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (wait_cnt >= lat) begin
                wait_cnt  = 0;
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                ack_count++;
                if (exp_addr_q.size() == 0)
                    chk("unexpected_mem_req", mem_addr, 32'hFFFF_FFFF);
                else
                    chk("mem_addr", mem_addr, exp_addr_q.pop_front());
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic expect_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++)
            exp_addr_q.push_back(base + 32'(4 * i));
    endtask

    // Called at posedge+2; returns the number of stalled cycles before cpu_ready.
    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, output int cyc);
        logic [31:0] e;
        exp_inst_q.push_back(exp);
        cpu_addr = a;
        cpu_req  = 1'b1;
        cyc      = 0;
        forever begin
            @(negedge clk);
            if (cpu_ready) begin
                e = exp_inst_q.pop_front();
                chk("cpu_inst", cpu_inst, e);
                break;
            end
            cyc++;
            if (cyc > 300) begin
                chk("fetch_timeout", 32'(cyc), 32'd0);
                void'(exp_inst_q.pop_front());
                break;
            end
        end
        @(posedge clk);
        #2;
        cpu_req = 1'b0;
    endtask

    task automatic pulse_flush();
        @(posedge clk);
        #2 flush = 1'b1;
        @(posedge clk);
        #2 flush = 1'b0;
    endtask

    initial begin
        int cyc;
        int a0;
        int n;

        repeat (2) @(posedge clk);
        #3;
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst_cpu_inst", cpu_inst, 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // 1: cold miss
        @(posedge clk);
        #2;
        expect_line(32'h0);
        fetch(32'h0, 32'h8C010001, cyc);
        chk("t1_stalled", 32'(cyc > 4), 32'd1);
        chk("t1_miss_cnt", 32'(miss_cnt), 32'd1);
        chk("t1_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("t1_addr_q_empty", 32'(exp_addr_q.size()), 32'd0);

        // 2: hits in the same line
        fetch(32'h4, 32'h24010005, cyc);
        chk("t2_hit4_latency", 32'(cyc), 32'd0);
        fetch(32'h8, 32'h10210007, cyc);
        chk("t2_hit8_latency", 32'(cyc), 32'd0);
        chk("t2_hit_cnt", 32'(hit_cnt), 32'd2);

        // 3: conflict eviction in set 0
        expect_line(32'h100);
        fetch(32'h100, 32'h11110100, cyc);
        chk("t3_100_miss", 32'(cyc > 0), 32'd1);
        expect_line(32'h0);
        fetch(32'h0, 32'h8C010001, cyc);
        chk("t3_0_miss", 32'(cyc > 0), 32'd1);
        chk("t3_miss_cnt", 32'(miss_cnt), 32'd3);

        // 4: set 1, hit, then flush forces a refill
        expect_line(32'h10);
        fetch(32'h18, 32'h00011021, cyc);
        fetch(32'h1C, 32'hAC620001, cyc);
        chk("t4_hit1c_latency", 32'(cyc), 32'd0);
        chk("t4_hit_cnt", 32'(hit_cnt), 32'd3);
        pulse_flush();
        expect_line(32'h10);
        fetch(32'h1C, 32'hAC620001, cyc);
        chk("t4_post_flush_miss", 32'(cyc > 0), 32'd1);
        chk("t4_miss_cnt", 32'(miss_cnt), 32'd5);

        // 5: flush during word 2 of a refill discards that line
        a0 = ack_count;
        expect_line(32'h0);
        expect_line(32'h0);
        fork
            fetch(32'h8, 32'h10210007, cyc);
            begin
                n = 0;
                while (ack_count < a0 + 2 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                pulse_flush();
            end
        join
        chk("t5_two_refills", 32'(ack_count - a0), 32'd8);
        chk("t5_miss_cnt", 32'(miss_cnt), 32'd7);
        chk("t5_hit_cnt", 32'(hit_cnt), 32'd3);

        // 6: async reset mid-refill with random latency
        lat = int'($urandom_range(0, 5));
        expect_line(32'h100);
        cpu_addr = 32'h100;
        cpu_req  = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_mem_req_drop", 32'(mem_req), 32'd0);
        chk("t6_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("t6_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("t6_cpu_ready", 32'(cpu_ready), 32'd0);
        cpu_req = 1'b0;
        exp_addr_q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
        expect_line(32'h0);
        fetch(32'h0, 32'h8C010001, cyc);
        chk("t6_refetch_miss", 32'(cyc > 0), 32'd1);
        chk("t6_miss_cnt_after", 32'(miss_cnt), 32'd1);

        repeat (3) @(posedge clk);
        chk("end_addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
        chk("end_inst_q_empty", 32'(exp_inst_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
